// File: rtl/framebuffer_write_adapter.sv
// -----------------------------------------------------------------------------
// framebuffer_write_adapter
//
// Purpose:
//   Takes the RAM write stream from control_cmd_readrow (row/column/pixel/data
//   with a toggling access-start strobe). Each write becomes a flat framebuffer
//   byte address, is held in a small FIFO, and is presented to the framebuffer
//   RAM port. The block pulses row_committed once every byte of a finished row
//   has been accepted by the RAM.
//
// Ports:
//   clk            system clock
//   reset          asynchronous, active-low reset
//   cmd_row        row address from readrow
//   cmd_column     column address
//   cmd_pixel      byte-in-pixel select
//   cmd_data       byte to write
//   cmd_we         write enable level
//   cmd_as         access-start toggle; every edge while cmd_we=1 is one write
//   cmd_done       one-cycle pulse: row stream complete
//   mem_addr       flat byte address to the RAM
//   mem_wdata      write data to the RAM
//   mem_we         write valid to the RAM
//   mem_ready      RAM ready
//   row_committed  one-cycle pulse once the row has fully drained to RAM
//   overflow_err   sticky: write dropped on a full buffer, or cmd_done repeated
//                  while a commit was already pending
//   range_err      sticky: write dropped because an address field is too large
//
// Handshake (RAM side): mem_we is the valid. Once mem_we=1, mem_addr/mem_wdata
// stay stable until a posedge with mem_ready=1; that posedge is the transfer.
// mem_ready may be asserted with mem_we=0 and then has no effect.
// -----------------------------------------------------------------------------
module framebuffer_write_adapter #(
  parameter int BYTES_PER_PIXEL = 2,
  parameter int PIXEL_HEIGHT    = 8,
  parameter int PIXEL_WIDTH     = 16,
  parameter int FIFO_DEPTH      = 4,
  // Field widths can represent the first out-of-range value so that a bad
  // address field is detectable rather than silently wrapping.
  localparam int RW   = $clog2(PIXEL_HEIGHT + 1),
  localparam int CW   = $clog2(PIXEL_WIDTH + 1),
  localparam int PW   = $clog2(BYTES_PER_PIXEL + 1),
  localparam int AW   = $clog2(PIXEL_HEIGHT * PIXEL_WIDTH * BYTES_PER_PIXEL),
  localparam int PTRW = $clog2(FIFO_DEPTH)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [RW-1:0] cmd_row,
  input  logic [CW-1:0] cmd_column,
  input  logic [PW-1:0] cmd_pixel,
  input  logic [7:0]    cmd_data,
  input  logic          cmd_we,
  input  logic          cmd_as,
  input  logic          cmd_done,
  output logic [AW-1:0] mem_addr,
  output logic [7:0]    mem_wdata,
  output logic          mem_we,
  input  logic          mem_ready,
  output logic          row_committed,
  output logic          overflow_err,
  output logic          range_err
);

  // ---------------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------------
  logic            r_prev_as;
  logic            r_pending_done;
  logic [PTRW-1:0] r_wr_ptr;
  logic [PTRW-1:0] r_rd_ptr;
  logic [PTRW:0]   r_fifo_cnt;
  logic [AW-1:0]   r_fifo_addr [FIFO_DEPTH];
  logic [7:0]      r_fifo_data [FIFO_DEPTH];
  logic [AW-1:0]   r_mem_addr;
  logic [7:0]      r_mem_wdata;
  logic            r_mem_we;
  logic            r_row_committed;
  logic            r_overflow_err;
  logic            r_range_err;

  // ---------------------------------------------------------------------------
  // Combinational control
  // ---------------------------------------------------------------------------
  logic            w_write_evt;
  logic            w_range_bad;
  logic [AW-1:0]   w_addr;
  logic [PTRW+1:0] w_occ;
  logic            w_full;
  logic            w_accept;
  logic            w_load;
  logic            w_push;
  logic            w_drop_full;
  logic            w_commit;

  assign w_write_evt = cmd_we && (cmd_as != r_prev_as);

  assign w_range_bad = (32'(cmd_row)    >= 32'(PIXEL_HEIGHT)) ||
                       (32'(cmd_column) >= 32'(PIXEL_WIDTH))  ||
                       (32'(cmd_pixel)  >= 32'(BYTES_PER_PIXEL));

  // In-range fields always fit in AW bits, so no wider intermediate is needed.
  assign w_addr = (AW'(cmd_row) * AW'(PIXEL_WIDTH) + AW'(cmd_column))
                  * AW'(BYTES_PER_PIXEL) + AW'(cmd_pixel);

  // Occupancy counts the entry sitting in the output register as well, so the
  // block buffers at most FIFO_DEPTH writes in total while the RAM stalls.
  assign w_occ    = (PTRW+2)'(r_fifo_cnt) + (PTRW+2)'(r_mem_we);
  assign w_full   = (w_occ >= (PTRW+2)'(FIFO_DEPTH));
  assign w_accept = r_mem_we && mem_ready;

  // Output register reloads whenever it is empty or being accepted.
  assign w_load = (!r_mem_we || mem_ready) && (r_fifo_cnt != '0);

  // A full buffer still takes a write if the RAM frees a slot this cycle.
  assign w_push      = w_write_evt && !w_range_bad && (!w_full || w_accept);
  assign w_drop_full = w_write_evt && !w_range_bad && !w_push;

  // Commit waits for every buffered byte (FIFO and output stage) to be
  // accepted, and for no new write entering this cycle.
  assign w_commit = r_pending_done && (w_occ == '0) && !w_push;

  // ---------------------------------------------------------------------------
  // FIFO storage (data only, no reset needed)
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_fifo_addr[r_wr_ptr] <= w_addr;
      r_fifo_data[r_wr_ptr] <= cmd_data;
    end
  end

  // ---------------------------------------------------------------------------
  // Control state
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_prev_as       <= 1'b0;
      r_pending_done  <= 1'b0;
      r_wr_ptr        <= '0;
      r_rd_ptr        <= '0;
      r_fifo_cnt      <= '0;
      r_mem_addr      <= '0;
      r_mem_wdata     <= '0;
      r_mem_we        <= 1'b0;
      r_row_committed <= 1'b0;
      r_overflow_err  <= 1'b0;
      r_range_err     <= 1'b0;
    end else begin
      r_prev_as <= cmd_as;

      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + 1'b1;
      end
      if (w_load) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
      end
      r_fifo_cnt <= r_fifo_cnt + (PTRW+1)'(w_push) - (PTRW+1)'(w_load);

      if (!r_mem_we || mem_ready) begin
        r_mem_we <= w_load;
        if (w_load) begin
          r_mem_addr  <= r_fifo_addr[r_rd_ptr];
          r_mem_wdata <= r_fifo_data[r_rd_ptr];
        end
      end

      // A second cmd_done while one is pending is not queued.
      if (w_commit) begin
        r_pending_done <= 1'b0;
      end else if (cmd_done) begin
        r_pending_done <= 1'b1;
      end
      r_row_committed <= w_commit;

      if (w_drop_full || (cmd_done && r_pending_done)) begin
        r_overflow_err <= 1'b1;
      end
      if (w_write_evt && w_range_bad) begin
        r_range_err <= 1'b1;
      end
    end
  end

  assign mem_addr      = r_mem_addr;
  assign mem_wdata     = r_mem_wdata;
  assign mem_we        = r_mem_we;
  assign row_committed = r_row_committed;
  assign overflow_err  = r_overflow_err;
  assign range_err     = r_range_err;

endmodule

// File: tb/tb_framebuffer_write_adapter.sv
// -----------------------------------------------------------------------------
// tb_framebuffer_write_adapter
//
// Self-checking bench for framebuffer_write_adapter. Expected RAM writes are
// pushed to exp_q as stimulus is driven and popped as the RAM port accepts.
// -----------------------------------------------------------------------------
module tb_framebuffer_write_adapter;

  localparam int BYTES_PER_PIXEL = 2;
  localparam int PIXEL_HEIGHT    = 8;
  localparam int PIXEL_WIDTH     = 16;
  localparam int FIFO_DEPTH      = 4;
  localparam int RW = $clog2(PIXEL_HEIGHT + 1);
  localparam int CW = $clog2(PIXEL_WIDTH + 1);
  localparam int PW = $clog2(BYTES_PER_PIXEL + 1);
  localparam int AW = $clog2(PIXEL_HEIGHT * PIXEL_WIDTH * BYTES_PER_PIXEL);

  // ---------------------------------------------------------------------------
  // Clock / reset
  // ---------------------------------------------------------------------------
  logic          clk = 1'b0;
  logic          reset;
  logic [RW-1:0] cmd_row;
  logic [CW-1:0] cmd_column;
  logic [PW-1:0] cmd_pixel;
  logic [7:0]    cmd_data;
  logic          cmd_we;
  logic          cmd_as;
  logic          cmd_done;
  logic [AW-1:0] mem_addr;
  logic [7:0]    mem_wdata;
  logic          mem_we;
  logic          mem_ready;
  logic          row_committed;
  logic          overflow_err;
  logic          range_err;

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  framebuffer_write_adapter #(
    .BYTES_PER_PIXEL(BYTES_PER_PIXEL),
    .PIXEL_HEIGHT   (PIXEL_HEIGHT),
    .PIXEL_WIDTH    (PIXEL_WIDTH),
    .FIFO_DEPTH     (FIFO_DEPTH)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .cmd_row      (cmd_row),
    .cmd_column   (cmd_column),
    .cmd_pixel    (cmd_pixel),
    .cmd_data     (cmd_data),
    .cmd_we       (cmd_we),
    .cmd_as       (cmd_as),
    .cmd_done     (cmd_done),
    .mem_addr     (mem_addr),
    .mem_wdata    (mem_wdata),
    .mem_we       (mem_we),
    .mem_ready    (mem_ready),
    .row_committed(row_committed),
    .overflow_err (overflow_err),
    .range_err    (range_err)
  );

  // ---------------------------------------------------------------------------
  // Scoreboard state and checking
  // ---------------------------------------------------------------------------
  logic [AW+7:0] exp_q[$];
  int n_tests  = 0;
  int n_fail   = 0;
  int n_accept = 0;
  int n_commit = 0;
  int last_accept_cyc = 0;
  int commit_cyc      = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic logic [AW-1:0] model_addr(input int row, input int col, input int pix);
    return AW'((row * PIXEL_WIDTH + col) * BYTES_PER_PIXEL + pix);
  endfunction

  // Sample 1 time unit after the falling edge: inputs driven on that edge are
  // settled and are exactly what the next rising edge will see.
  always @(negedge clk) begin
    logic [AW+7:0] e;
    #1;
    if (reset && mem_we && mem_ready) begin
      n_accept++;
      last_accept_cyc = cyc;
      check_eq("sb_avail", 32'(exp_q.size() > 0), 32'd1);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check_eq("sb_addr", 32'(mem_addr), 32'(e[AW+7:8]));
        check_eq("sb_data", 32'(mem_wdata), 32'(e[7:0]));
      end
    end
    if (row_committed) begin
      n_commit++;
      commit_cyc = cyc;
    end
  end

  // ---------------------------------------------------------------------------
  // Driver tasks
  // ---------------------------------------------------------------------------
  task automatic drive_write(input int row, input int col, input int pix,
                             input logic [7:0] data, input bit expect_push);
    @(negedge clk);
    cmd_row    = RW'(row);
    cmd_column = CW'(col);
    cmd_pixel  = PW'(pix);
    cmd_data   = data;
    cmd_we     = 1'b1;
    cmd_as     = ~cmd_as;
    if (expect_push) exp_q.push_back({model_addr(row, col, pix), data});
  endtask

  task automatic stop_writes();
    @(negedge clk);
    cmd_we = 1'b0;
  endtask

  task automatic pulse_done();
    @(negedge clk);
    cmd_done = 1'b1;
    @(negedge clk);
    cmd_done = 1'b0;
  endtask

  task automatic wait_drain(input string tag);
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (exp_q.size() == 0 && !mem_we) break;
    end
    check_eq(tag, 32'(exp_q.size()), 32'd0);
  endtask

  // ---------------------------------------------------------------------------
  // Stimulus
  // ---------------------------------------------------------------------------
  initial begin
    int acc0;
    int com0;

    reset = 1'b0;
    cmd_row = '0; cmd_column = '0; cmd_pixel = '0; cmd_data = '0;
    cmd_we = 1'b0; cmd_as = 1'b0; cmd_done = 1'b0; mem_ready = 1'b0;
    repeat (3) @(negedge clk);
    check_eq("rst_mem_we",    32'(mem_we), 32'd0);
    check_eq("rst_mem_addr",  32'(mem_addr), 32'd0);
    check_eq("rst_commit",    32'(row_committed), 32'd0);
    check_eq("rst_overflow",  32'(overflow_err), 32'd0);
    check_eq("rst_range",     32'(range_err), 32'd0);
    reset = 1'b1;
    mem_ready = 1'b1;
    repeat (2) @(negedge clk);

    // Single write: (3*16+5)*2+1 = 107.
    acc0 = n_accept;
    drive_write(3, 5, 1, 8'hA5, 1'b1);
    @(posedge clk);
    @(posedge clk); #1;
    check_eq("single_we",    32'(mem_we), 32'd1);
    check_eq("single_addr",  32'(mem_addr), 32'd107);
    check_eq("single_data",  32'(mem_wdata), 32'hA5);
    @(posedge clk); #1;
    check_eq("single_we_low", 32'(mem_we), 32'd0);
    stop_writes();
    wait_drain("single_drain");
    check_eq("single_count", 32'(n_accept - acc0), 32'd1);

    // Full row stream, descending column/pixel, done on the last write.
    acc0 = n_accept;
    com0 = n_commit;
    for (int c = PIXEL_WIDTH - 1; c >= 0; c--) begin
      for (int p = BYTES_PER_PIXEL - 1; p >= 0; p--) begin
        drive_write(5, c, p, 8'($urandom_range(0, 255)), 1'b1);
      end
    end
    cmd_done = 1'b1;
    @(negedge clk);
    cmd_done = 1'b0;
    cmd_we   = 1'b0;
    wait_drain("row_drain");
    repeat (4) @(negedge clk);
    check_eq("row_accepts", 32'(n_accept - acc0), 32'(PIXEL_WIDTH * BYTES_PER_PIXEL));
    check_eq("row_commits", 32'(n_commit - com0), 32'd1);
    check_eq("row_commit_after_last", 32'(commit_cyc > last_accept_cyc), 32'd1);
    check_eq("row_no_overflow", 32'(overflow_err), 32'd0);

    // Toggle with cmd_we=0 is not a write; done with empty pipeline commits.
    acc0 = n_accept;
    com0 = n_commit;
    @(negedge clk);
    cmd_we = 1'b0;
    cmd_as = ~cmd_as;
    repeat (4) @(negedge clk);
    check_eq("we0_no_write", 32'(n_accept - acc0), 32'd0);
    check_eq("we0_mem_we",   32'(mem_we), 32'd0);
    @(negedge clk);
    cmd_done = 1'b1;
    @(negedge clk);
    cmd_done = 1'b0;
    check_eq("done_not_same_cycle", 32'(row_committed), 32'd0);
    @(posedge clk); #1;
    check_eq("done_commit", 32'(row_committed), 32'd1);
    @(posedge clk); #1;
    check_eq("done_commit_1cyc", 32'(row_committed), 32'd0);
    check_eq("done_commit_count", 32'(n_commit - com0), 32'd1);

    // Range errors: column, row and pixel each one past the end.
    acc0 = n_accept;
    drive_write(0, PIXEL_WIDTH, 0, 8'h5A, 1'b0);
    stop_writes();
    check_eq("range_err_set", 32'(range_err), 32'd1);
    check_eq("range_mem_we",  32'(mem_we), 32'd0);
    drive_write(PIXEL_HEIGHT, 0, 0, 8'h5B, 1'b0);
    drive_write(1, 1, BYTES_PER_PIXEL, 8'h5C, 1'b0);
    stop_writes();
    repeat (4) @(negedge clk);
    check_eq("range_no_accept", 32'(n_accept - acc0), 32'd0);
    check_eq("range_no_ovf",    32'(overflow_err), 32'd0);

    // Backpressure: 4 buffered, 5th dropped.
    @(negedge clk);
    mem_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      drive_write(1, i, 0, 8'(8'h30 + i), i < FIFO_DEPTH);
    end
    stop_writes();
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check_eq("bp_hold_we",   32'(mem_we), 32'd1);
      check_eq("bp_hold_addr", 32'(mem_addr), 32'(model_addr(1, 0, 0)));
      check_eq("bp_hold_data", 32'(mem_wdata), 32'h30);
    end
    check_eq("bp_overflow", 32'(overflow_err), 32'd1);
    mem_ready = 1'b1;
    wait_drain("bp_drain");

    // Reset mid-stream with entries buffered and a commit pending.
    acc0 = n_accept;
    @(negedge clk);
    mem_ready = 1'b0;
    for (int i = 0; i < 3; i++) drive_write(4, i, 1, 8'(8'hC0 + i), 1'b1);
    stop_writes();
    pulse_done();
    reset = 1'b0;
    #1;
    check_eq("mid_rst_we",       32'(mem_we), 32'd0);
    check_eq("mid_rst_addr",     32'(mem_addr), 32'd0);
    check_eq("mid_rst_data",     32'(mem_wdata), 32'd0);
    check_eq("mid_rst_commit",   32'(row_committed), 32'd0);
    check_eq("mid_rst_overflow", 32'(overflow_err), 32'd0);
    check_eq("mid_rst_range",    32'(range_err), 32'd0);
    exp_q.delete();
    repeat (2) @(negedge clk);
    reset = 1'b1;
    mem_ready = 1'b1;
    com0 = n_commit;
    repeat (10) @(negedge clk);
    check_eq("post_rst_no_we",     32'(n_accept - acc0), 32'd0);
    check_eq("post_rst_no_commit", 32'(n_commit - com0), 32'd0);

    // Repeated done while pending: one commit, overflow_err set.
    com0 = n_commit;
    mem_ready = 1'b0;
    drive_write(2, 3, 0, 8'h11, 1'b1);
    stop_writes();
    pulse_done();
    pulse_done();
    check_eq("dbl_done_ovf",       32'(overflow_err), 32'd1);
    check_eq("dbl_done_no_commit", 32'(n_commit - com0), 32'd0);
    mem_ready = 1'b1;
    wait_drain("dbl_done_drain");
    repeat (4) @(negedge clk);
    check_eq("dbl_done_commits", 32'(n_commit - com0), 32'd1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached (cycle %0d)", cyc);
    $fatal(1);
  end

endmodule
